gnn_input_loader: RTL and testbench
===================================

# gnn_input_loader

Streaming front-end for the GNN `top` datapath. It accepts the 16 node features and 24 weights of one inference as a serial stream of 5-bit signed words under a valid/ready handshake. It assembles them in a shadow buffer and presents them as parallel buses. It raises `in_ready` to launch the computation and holds the operands stable until the downstream completion signal returns.

## Interface
Parameters:
- `WORDS`, 40: words per frame (16 features + 24 weights); fixed, not for override.
- `CNT_W`, 8: width of `frame_cnt`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `s_valid`  in  1  stream word valid.
- `s_data`  in  5  stream word, two's complement.
- `s_last`  in  1  marks the final word of a frame; used only with `GNN_LOADER_FRAME_CHECK_EN`.
- `s_ready`  out  1  loader accepts a word this cycle.
- `done_i`  in  1  downstream completion (AND of all `out1x_ready_nodeN`).
- `feat_bus`  out  80  features; node n, feature f at `[5*(4n+f) +: 5]` (maps to `xf_noden`).
- `wgt_bus`  out  120  weights; slot k at `[5*k +: 5]`. Order k=0..23: w04,w14,w24,w34, w05,w15,w25,w35, w06,w16,w26,w36, w07,w17,w27,w37, w48,w58,w68,w78, w49,w59,w69,w79.
- `in_ready`  out  1  operands valid, connects to `top.in_ready`.
- `frame_cnt`  out  CNT_W  count of frames presented.
- `frame_err`  out  1  one-cycle framing error pulse.

## Operation
- The FSM has three states: IDLE, LOAD and PRESENT.
- Reset forces IDLE. The first clock after reset release moves IDLE to LOAD.
- `s_ready` is 1 only in LOAD. It is decoded from the state register, with no combinational path from `s_valid`.
- Accept condition: `s_valid && s_ready`. Each accept writes `s_data` into shadow slot `cnt`, then increments `cnt` (0..39).
  - Slots 0..15 hold features in stream order node0 f0..f3, node1 f0..f3, and so on.
  - Slots 16..39 hold weights in the order k listed above.
- Accepting the word at `cnt`=39 completes the frame, with these effects at that same edge:
  - copy the shadow buffer to `feat_bus`/`wgt_bus`;
  - set `in_ready`=1;
  - set `cnt`=0;
  - increment `frame_cnt`;
  - state becomes PRESENT.
- In PRESENT:
  - `s_ready`=0, and stream words are not consumed.
  - The buses and `in_ready` hold.
  - The first edge with `done_i`=1 clears `in_ready` and returns the FSM to LOAD.
  - The buses keep their last values until the next frame completes.
- `done_i` outside PRESENT is ignored.
- `frame_cnt` wraps from 2^CNT_W−1 to 0.
- No arithmetic is performed. The data is pass-through; sign is preserved bit-exact.

## Timing
- Reset values:
  - `s_ready`=0, `in_ready`=0, `frame_err`=0;
  - `feat_bus`=0, `wgt_bus`=0, `frame_cnt`=0;
  - internal `cnt`=0, shadow buffer=0.
- Reset asserted mid-frame or in PRESENT: the partial frame is lost and every output returns to its reset value immediately (asynchronous).
- Minimum frame time is 40 cycles of continuous `s_valid`. `in_ready` rises on the edge accepting word 39.
- PRESENT→LOAD takes one edge after `done_i`. `s_ready` is high in the following cycle.
- If `s_valid` stays high across PRESENT, no word is accepted until `s_ready` returns. There is no loss and no duplication.
- `s_data` must be stable only while `s_valid && s_ready`.

## Configuration
- Macro: `GNN_LOADER_FRAME_CHECK_EN`.
- When defined, framing is checked on each accept. An error is either of:
  - `s_last`=1 with `cnt`≠39;
  - `s_last`=0 with `cnt`=39.
- On an error, at that edge:
  - `frame_err` pulses high for one cycle;
  - `cnt`=0 and the shadow buffer is discarded;
  - the FSM stays in LOAD;
  - `feat_bus`, `wgt_bus`, `in_ready` and `frame_cnt` are unchanged.
- When undefined, `s_last` is ignored and `frame_err` is tied 0.

## Test plan
- **Maximum frame:** reset, then stream 40 words of 5'd15 back-to-back.
  - `in_ready` rises after the 40th accept; `s_ready` falls.
  - `feat_bus`=80'h…all 5'b01111 fields, and likewise `wgt_bus`; `frame_cnt`=1.
  - With `top` attached, every output reads 486000.
- **Minimum frame:** stream 40 words of −5'd16.
  - All bus fields are 5'b10000.
  - With `top` attached, outputs read −589824.
- **Mixed-sign frame and ordering:** stream features 4,2,4,1, 6,4,4,1, 8,6,4,1, 6,4,4,1, then weights 3,2,13,−6, −9,1,−4,14, 3,6,−15,15, 9,−10,15,−10, 0,−1,3,−11, −12,−15,−15,6 in k order.
  - Each field lands at its specified offset; for example `wgt_bus[119:115]`=5'd6 and `feat_bus[4:0]`=5'd4.
  - With `top` attached, the outputs of node0 are −6358 and −4188.
- **Backpressure/handshake:**
  - Keep `s_valid`=1 through PRESENT for 10 cycles: zero accepts and the buses are stable.
  - Pulse `done_i`: `in_ready` is 0 the next cycle and `s_ready` is 1.
  - Insert random `s_valid` gaps within a frame: the assembled values are identical to the gap-free case.
- **Reset mid-frame:** assert `rst` after 20 accepts.
  - All outputs are 0 immediately.
  - After release, a full 40-word frame loads correctly with `frame_cnt`=1.
- **Framing check (macro defined):** set `s_last`=1 on word 25.
  - `frame_err` pulses once and `in_ready` stays 0.
  - A following correct frame presents with `frame_cnt` incremented by exactly 1.
  - With the macro undefined, the same stimulus produces no `frame_err`; word 25 is stored as data and the frame continues counting.

Source files
------------

// File: rtl/gnn_input_loader_if.sv
// Stream, completion and operand-bus bundle for gnn_input_loader.
// master drives the word stream and done; slave is the loader.
interface gnn_input_loader_if #(
  parameter int CNT_W = 8
);
  logic             s_valid;
  logic [4:0]       s_data;
  logic             s_last;
  logic             s_ready;
  logic             done_i;
  logic [79:0]      feat_bus;
  logic [119:0]     wgt_bus;
  logic             in_ready;
  logic [CNT_W-1:0] frame_cnt;
  logic             frame_err;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    output done_i,
    input  s_ready,
    input  feat_bus,
    input  wgt_bus,
    input  in_ready,
    input  frame_cnt,
    input  frame_err
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    input  done_i,
    output s_ready,
    output feat_bus,
    output wgt_bus,
    output in_ready,
    output frame_cnt,
    output frame_err
  );
endinterface

// File: rtl/gnn_input_loader.sv
// Serial-to-parallel operand loader for the GNN datapath.
// Optional framing check via `define GNN_LOADER_FRAME_CHECK_EN.
module gnn_input_loader #(
  parameter int WORDS = 40,
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst,
  gnn_input_loader_if.slave bus
);
  localparam int SH_W = 5 * WORDS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PRESENT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [5:0]       r_cnt;
  logic [5:0]       w_cnt_nxt;
  logic [SH_W-1:0]  r_shadow;
  logic [SH_W-1:0]  w_shadow_nxt;
  logic [79:0]      r_feat;
  logic [119:0]     r_wgt;
  logic             r_in_ready;
  logic             w_in_ready_nxt;
  logic [CNT_W-1:0] r_frame_cnt;
  logic             r_frame_err;
  logic             w_accept;
  logic             w_last_slot;
  logic             w_err;
  logic             w_done_frame;

  assign w_accept    = bus.s_valid && (r_state == S_LOAD);
  assign w_last_slot = (r_cnt == 6'(WORDS - 1));

`ifdef GNN_LOADER_FRAME_CHECK_EN
  assign w_err = w_accept && (bus.s_last != w_last_slot);
`else
  assign w_err = 1'b0;
`endif

  assign w_done_frame = w_accept && w_last_slot && !w_err;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_shadow_nxt   = r_shadow;
    w_in_ready_nxt = r_in_ready;
    unique case (r_state)
      S_IDLE: w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (w_accept) begin
          w_shadow_nxt[5*r_cnt +: 5] = bus.s_data;
          w_cnt_nxt = r_cnt + 6'd1;
          if (w_err) begin
            // malformed frame: drop everything gathered so far
            w_cnt_nxt    = '0;
            w_shadow_nxt = '0;
          end else if (w_last_slot) begin
            w_cnt_nxt      = '0;
            w_in_ready_nxt = 1'b1;
            w_state_nxt    = S_PRESENT;
          end
        end
      end
      S_PRESENT: begin
        if (bus.done_i) begin
          w_in_ready_nxt = 1'b0;
          w_state_nxt    = S_LOAD;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_shadow    <= '0;
      r_feat      <= '0;
      r_wgt       <= '0;
      r_in_ready  <= 1'b0;
      r_frame_cnt <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_shadow    <= w_shadow_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_frame_err <= w_err;
      if (w_done_frame) begin
        r_feat      <= w_shadow_nxt[79:0];
        r_wgt       <= w_shadow_nxt[SH_W-1:80];
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign bus.s_ready   = (r_state == S_LOAD);
  assign bus.feat_bus  = r_feat;
  assign bus.wgt_bus   = r_wgt;
  assign bus.in_ready  = r_in_ready;
  assign bus.frame_cnt = r_frame_cnt;
  assign bus.frame_err = r_frame_err;
endmodule

// File: tb/tb_gnn_input_loader.sv
// Scoreboard bench for gnn_input_loader.
// Driver pushes expected operand frames; monitor checks on in_ready rise.
module tb_gnn_input_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gnn_input_loader_if #(.CNT_W(8)) bus ();

  gnn_input_loader #(.WORDS(40), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [79:0]  f;
    logic [119:0] w;
    logic [7:0]   c;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   model_frames = 0;
  int   err_pulses = 0;
  logic prev_ir = 1'b0;

  int wd[40];
  int mixed[40] = '{4, 2, 4, 1, 6, 4, 4, 1, 8, 6, 4, 1, 6, 4, 4, 1,
                    3, 2, 13, -6, -9, 1, -4, 14, 3, 6, -15, 15,
                    9, -10, 15, -10, 0, -1, 3, -11, -12, -15, -15, 6};

  task automatic check(string name, logic [199:0] act, logic [199:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: node n feature f is stream word 4n+f; weight k is word 16+k.
  function automatic exp_t model(input int w[40], input int frames);
    exp_t e;
    e.f = '0;
    e.w = '0;
    for (int n = 0; n < 4; n++)
      for (int f = 0; f < 4; f++)
        e.f[5*(4*n+f) +: 5] = 5'(w[4*n+f]);
    for (int k = 0; k < 24; k++)
      e.w[5*k +: 5] = 5'(w[16+k]);
    e.c = 8'(frames % 256);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_ir = 1'b0;
    end else begin
      if (bus.frame_err) err_pulses++;
      if (bus.in_ready && !prev_ir) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame actual=1 required=0");
        end else begin
          e = sbq.pop_front();
          check("feat_bus", bus.feat_bus, e.f);
          check("wgt_bus", bus.wgt_bus, e.w);
          check("frame_cnt", bus.frame_cnt, e.c);
        end
      end
      prev_ir = bus.in_ready;
    end
  end

  task automatic put_word(input int d, input bit last);
    int n;
    bus.s_valid = 1'b1;
    bus.s_data  = 5'(d);
    bus.s_last  = last;
    bus.done_i  = 1'b0;
    n = 0;
    while (!bus.s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=0 required=1");
    end
    @(negedge clk);
  endtask

  task automatic gap(input int pct);
    if ($urandom_range(0, 99) < pct) begin
      bus.s_valid = 1'b0;
      repeat ($urandom_range(1, 3)) begin
        bus.done_i = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
  endtask

  task automatic send_frame(input int w[40], input int pct, input bit hold);
    for (int i = 0; i < 40; i++) begin
      gap(pct);
      if (i == 39) begin
        model_frames++;
        sbq.push_back(model(w, model_frames));
      end
      put_word(w[i], i == 39);
    end
    if (!hold) bus.s_valid = 1'b0;
  endtask

  task automatic release_frame();
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL present_timeout actual=0 required=1");
    end
    repeat ($urandom_range(0, 3)) @(negedge clk);
    bus.done_i = 1'b1;
    @(negedge clk);
    bus.done_i = 1'b0;
  endtask

  task automatic rand_words();
    for (int i = 0; i < 40; i++) wd[i] = int'($urandom_range(0, 31)) - 16;
  endtask

  task automatic check_zero(string tag);
    check({tag, "_s_ready"}, bus.s_ready, 0);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_frame_err"}, bus.frame_err, 0);
    check({tag, "_feat"}, bus.feat_bus, 0);
    check({tag, "_wgt"}, bus.wgt_bus, 0);
    check({tag, "_cnt"}, bus.frame_cnt, 0);
  endtask

  initial begin
    exp_t e;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.done_i  = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 40; i++) wd[i] = 15;
    send_frame(wd, 0, 1'b0);
    e = model(wd, 1);
    check("max_s_ready", bus.s_ready, 0);
    check("max_in_ready", bus.in_ready, 1);
    check("max_cnt", bus.frame_cnt, 1);

    // s_valid held high across PRESENT: nothing may be consumed
    for (int i = 0; i < 40; i++) wd[i] = -16;
    bus.s_valid = 1'b1;
    bus.s_data  = 5'(wd[0]);
    bus.s_last  = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("bp_s_ready", bus.s_ready, 0);
      check("bp_feat", bus.feat_bus, e.f);
      check("bp_wgt", bus.wgt_bus, e.w);
    end
    bus.done_i = 1'b1;
    @(negedge clk);
    bus.done_i = 1'b0;
    check("done_in_ready", bus.in_ready, 0);
    check("done_s_ready", bus.s_ready, 1);
    send_frame(wd, 0, 1'b0);
    release_frame();

    send_frame(mixed, 40, 1'b0);
    check("mixed_w23", bus.wgt_bus[119:115], 5'd6);
    check("mixed_f0", bus.feat_bus[4:0], 5'd4);
    check("mixed_w0", bus.wgt_bus[4:0], 5'd3);
    check("mixed_f15", bus.feat_bus[79:75], 5'd1);
    release_frame();
    send_frame(mixed, 60, 1'b0);
    release_frame();

    repeat (4) begin
      rand_words();
      send_frame(wd, 50, 1'b0);
      release_frame();
    end

    rand_words();
    for (int i = 0; i < 20; i++) put_word(wd[i], 1'b0);
    bus.s_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    model_frames = 0;
    rand_words();
    send_frame(wd, 20, 1'b0);
    check("post_rst_cnt", bus.frame_cnt, 1);
    release_frame();

    // s_last asserted early on word 25
    err_pulses = 0;
    rand_words();
    for (int i = 0; i < 25; i++) put_word(wd[i], i == 24);
`ifdef GNN_LOADER_FRAME_CHECK_EN
    bus.s_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("ferr_pulses", err_pulses, 1);
    check("ferr_in_ready", bus.in_ready, 0);
`else
    for (int i = 25; i < 40; i++) begin
      if (i == 39) begin
        model_frames++;
        sbq.push_back(model(wd, model_frames));
      end
      put_word(wd[i], i == 39);
    end
    bus.s_valid = 1'b0;
    @(negedge clk);
    check("ferr_pulses", err_pulses, 0);
    release_frame();
`endif
    rand_words();
    send_frame(wd, 10, 1'b0);
    check("ferr_next_cnt", bus.frame_cnt, 8'(model_frames));
    release_frame();

    repeat (256) begin
      rand_words();
      send_frame(wd, 0, 1'b0);
      release_frame();
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
